// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and state encoding for the cache miss fill controller.
package cache_fill_fsm_pkg;

  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned CNT_W       = $clog2(BLOCK_WORDS);
  localparam int unsigned OFFSET_BITS = 4;
  localparam int unsigned WORD_BYTES  = 2;
  localparam int unsigned WORD_SHIFT  = $clog2(WORD_BYTES);

  typedef enum logic {
    StIdle = 1'b0,
    StFill = 1'b1
  } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count flag.
module fill_counter #(
  parameter int unsigned Width    = 3,
  parameter int unsigned Terminal = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [Width-1:0] cnt,
  output logic             tc
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == Width'(Terminal));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the pipeline, streams one block of word reads
// from main memory into the data array, then writes the tag.
module cache_fill_fsm #(
  parameter int unsigned BLOCK_WORDS = cache_fill_fsm_pkg::BLOCK_WORDS,
  parameter int unsigned ADDR_W      = cache_fill_fsm_pkg::ADDR_W,
  parameter int unsigned CNT_W       = cache_fill_fsm_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] memory_address,
  input  logic              memory_data_valid,
  input  logic [15:0]       memory_data,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] fill_offset,
  output logic [15:0]       fill_data
);

  import cache_fill_fsm_pkg::*;

  fill_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic              start;
  logic              issue_en, issue_done;
  logic              recv_en, recv_last;
  logic [CNT_W:0]    issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;

  // Byte offset within the block never reaches memory or the arrays.
  logic unused_offset;
  assign unused_offset = ^miss_address[OFFSET_BITS-1:0];

  assign start = (state_q == StIdle) & miss_detected;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        base_q <= {miss_address[ADDR_W-1:OFFSET_BITS], OFFSET_BITS'(0)};
      end
    end
  end

  fill_counter #(
    .Width    (CNT_W + 1),
    .Terminal (BLOCK_WORDS)
  ) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (issue_en),
    .cnt   (issue_cnt),
    .tc    (issue_done)
  );

  // Narrow receive counter wraps to zero after the last word of the block.
  fill_counter #(
    .Width    (CNT_W),
    .Terminal (BLOCK_WORDS - 1)
  ) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (recv_en),
    .cnt   (recv_cnt),
    .tc    (recv_last)
  );

  always_comb begin
    state_d          = state_q;
    fsm_busy         = 1'b0;
    mem_rd_en        = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    fill_offset      = '0;
    issue_en         = 1'b0;
    recv_en          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (miss_detected) begin
          fsm_busy = 1'b1;
          state_d  = StFill;
        end
      end
      StFill: begin
        fsm_busy = 1'b1;
        if (!issue_done) begin
          mem_rd_en      = 1'b1;
          issue_en       = 1'b1;
          memory_address = base_q + (ADDR_W'(issue_cnt) << WORD_SHIFT);
        end
        // Returns are paced purely by memory_data_valid; latency is not assumed.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          recv_en          = 1'b1;
          fill_offset      = base_q + (ADDR_W'(recv_cnt) << WORD_SHIFT);
          if (recv_last) begin
            write_tag_array = 1'b1;
            state_d         = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign fill_data = memory_data;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with hand-computed per-cycle expectations.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        fsm_busy, mem_rd_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_offset, fill_data;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] LatMask   = 32'h0000_1FE0;  // valid on cycles 5..12
  localparam logic [31:0] IrregMask = 32'h0008_D960;  // valid on 5,6,8,11,12,14,15,19

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .fsm_busy          (fsm_busy),
    .mem_rd_en         (mem_rd_en),
    .memory_address    (memory_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_offset       (fill_offset),
    .fill_data         (fill_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic outs(input string tag, input bit busy, input bit rd, input logic [15:0] maddr,
                      input bit wd, input bit wt, input logic [15:0] foff,
                      input logic [15:0] fdata);
    check({tag, " busy"}, 16'(fsm_busy), 16'(busy));
    check({tag, " rd_en"}, 16'(mem_rd_en), 16'(rd));
    check({tag, " mem_addr"}, memory_address, maddr);
    check({tag, " wr_data"}, 16'(write_data_array), 16'(wd));
    check({tag, " wr_tag"}, 16'(write_tag_array), 16'(wt));
    check({tag, " fill_off"}, fill_offset, foff);
    if (wd) check({tag, " fill_data"}, fill_data, fdata);
  endtask

  // Drive one cycle's inputs just after the edge, sample mid-cycle, advance.
  task automatic cyc(input string tag, input bit miss, input logic [15:0] maddr_in,
                     input bit valid, input logic [15:0] data, input bit busy, input bit rd,
                     input logic [15:0] maddr, input bit wd, input bit wt,
                     input logic [15:0] foff);
    miss_detected     = miss;
    miss_address      = maddr_in;
    memory_data_valid = valid;
    memory_data       = data;
    #2;
    outs(tag, busy, rd, maddr, wd, wt, foff, data);
    @(posedge clk);
    #1;
  endtask

  // Miss at cycle 0, reads expected on cycles 1..8, returns wherever vmask says.
  task automatic fill_seq(input string tag, input logic [15:0] maddr_in,
                          input logic [15:0] base, input logic [31:0] vmask, input int last,
                          input bit intrude);
    int k;
    bit rd, wd;
    k = 0;
    cyc($sformatf("%s c0", tag), 1'b1, maddr_in, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0,
        16'h0);
    for (int c = 1; c <= last; c++) begin
      rd = (c <= 8);
      wd = vmask[c];
      cyc($sformatf("%s c%0d", tag, c), intrude && (c == 3), intrude ? 16'h4000 : maddr_in,
          wd, 16'hD000 + 16'(c), 1'b1, rd, rd ? base + 16'(2 * (c - 1)) : 16'h0, wd,
          wd && (k == 7), wd ? base + 16'(2 * k) : 16'h0);
      if (wd) k++;
    end
  endtask

  initial begin
    // Reset state
    #3;
    outs("reset", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Nominal fill, latency 4
    fill_seq("t1", 16'h1236, 16'h1230, LatMask, 12, 1'b0);
    cyc("t1 c13", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    // Stray valid in IDLE
    cyc("t2 stray", 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    cyc("t2 after", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    // Miss to 0x4000 during fill must be ignored
    fill_seq("t3", 16'h1230, 16'h1230, LatMask, 12, 1'b1);
    cyc("t3 c13", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    // Back-to-back misses
    fill_seq("t4a", 16'h0010, 16'h0010, LatMask, 12, 1'b0);
    fill_seq("t4b", 16'h0020, 16'h0020, LatMask, 12, 1'b0);
    cyc("t4 c13", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    // Reset at cycle 7 of a fill
    fill_seq("t5", 16'h5678, 16'h5670, LatMask, 6, 1'b0);
    miss_detected     = 1'b0;
    memory_data_valid = 1'b1;
    memory_data       = 16'hD007;
    rst_n             = 1'b0;
    #2;
    outs("t5 rst", 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("t5 late%0d", i), 1'b0, 16'h0, 1'b1, 16'hE000 + 16'(i), 1'b0, 1'b0, 16'h0,
          1'b0, 1'b0, 16'h0);
    end

    // Fresh fill after reset with irregular return gaps
    fill_seq("t6", 16'h5678, 16'h5670, IrregMask, 19, 1'b0);
    cyc("t6 idle", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
